// File: rtl/cpu_pkg.sv
// Shared types and widths for the data memory port and its RAM.
package cpu_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned REG_IDX_W = 4;
  localparam int unsigned MADDR_W   = 16;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  // Request captured at acceptance; both=1 marks a load|store collision.
  typedef struct packed {
    logic [MADDR_W-1:0]   addr;
    logic [DATA_W-1:0]    data;
    logic [REG_IDX_W-1:0] dest;
    logic                 is_store;
    logic                 both;
  } req_t;

  function automatic logic addr_in_range(input logic [MADDR_W-1:0] a,
                                         input int unsigned aw);
    return (a >> aw) == '0;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM, synchronous write and registered read, no reset.
module dmem_ram
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_port.sv
// Memory-side end of the register file interface: wait-stated RAM access
// with pipeline stall and a one-cycle register-file write for loads.
module data_mem_port
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 store,
  input  logic [MADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]    dataToMem,
  input  logic [REG_IDX_W-1:0] destReg,
  output logic                 stall,
  output logic [DATA_W-1:0]    writeData,
  output logic [REG_IDX_W-1:0] writeReg,
  output logic                 write,
  output logic                 fault
);

  localparam logic [CNT_W-1:0] WAIT_LOAD =
    CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  state_e               state_q, state_d;
  req_t                 req_q, req_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [REG_IDX_W-1:0] wreg_q, wreg_d;
  logic                 write_q, write_d;
  logic                 fault_q, fault_d;
  logic                 stall_c;
  logic                 ram_we;
  logic                 req_ok;
  logic [DATA_W-1:0]    ram_rdata;

  // The RAM is addressed from req_d so its registered read lands in ACCESS.
  dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (req_d.addr[ADDR_W-1:0]),
    .wdata (req_q.data),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    wreg_d  = wreg_q;
    write_d = 1'b0;
    fault_d = 1'b0;
    ram_we  = 1'b0;
    stall_c = 1'b0;
    req_ok  = addr_in_range(req_q.addr, ADDR_W);

    case (state_q)
      S_IDLE, S_RESP: begin
        if (load | store) begin
          stall_c = 1'b1;
          req_d   = '{addr: address, data: dataToMem, dest: destReg,
                      is_store: store, both: load & store};
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = S_ACCESS;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        stall_c = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ACCESS: begin
        stall_c = 1'b1;
        state_d = S_RESP;
        fault_d = req_q.both | ~req_ok;
        if (req_q.is_store) begin
          ram_we = req_ok;
        end else begin
          write_d = 1'b1;
          wreg_d  = req_q.dest;
          wdata_d = req_ok ? ram_rdata : '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      wreg_q  <= '0;
      write_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      wreg_q  <= wreg_d;
      write_q <= write_d;
      fault_q <= fault_d;
    end
  end

  assign stall     = stall_c;
  assign writeData = wdata_q;
  assign writeReg  = wreg_q;
  assign write     = write_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_data_mem_port.sv
// Directed bench: one port with one wait state, one with none.
module tb_data_mem_port;

  logic clk = 1'b0;
  logic reset;

  logic        a_load, a_store;
  logic [15:0] a_address, a_data;
  logic [3:0]  a_dest;
  logic        a_stall, a_write, a_fault;
  logic [15:0] a_wdata;
  logic [3:0]  a_wreg;

  logic        b_load, b_store;
  logic [15:0] b_address, b_data;
  logic [3:0]  b_dest;
  logic        b_stall, b_write, b_fault;
  logic [15:0] b_wdata;
  logic [3:0]  b_wreg;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  data_mem_port #(.ADDR_W(8), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .reset(reset), .load(a_load), .store(a_store),
    .address(a_address), .dataToMem(a_data), .destReg(a_dest),
    .stall(a_stall), .writeData(a_wdata), .writeReg(a_wreg),
    .write(a_write), .fault(a_fault)
  );

  data_mem_port #(.ADDR_W(8), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .load(b_load), .store(b_store),
    .address(b_address), .dataToMem(b_data), .destReg(b_dest),
    .stall(b_stall), .writeData(b_wdata), .writeReg(b_wreg),
    .write(b_write), .fault(b_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_load = 1'b0; a_store = 1'b0;
  endtask

  // Full transaction on the one-wait-state port, starting just after an edge.
  task automatic txn1(input string tag, input logic ld, input logic st,
                      input logic [15:0] ad, input logic [15:0] dt, input logic [3:0] dr,
                      input logic exp_w, input logic [15:0] exp_d, input logic exp_f);
    a_load = ld; a_store = st; a_address = ad; a_data = dt; a_dest = dr;
    #1;
    chk({tag, ".c0_stall"}, 32'(a_stall), 32'd1);
    chk({tag, ".c0_write"}, 32'(a_write), 32'd0);
    step(); a_idle(); #1;
    chk({tag, ".c1_stall"}, 32'(a_stall), 32'd1);
    chk({tag, ".c1_write"}, 32'(a_write), 32'd0);
    step(); #1;
    chk({tag, ".c2_stall"}, 32'(a_stall), 32'd1);
    chk({tag, ".c2_fault"}, 32'(a_fault), 32'd0);
    step(); #1;
    chk({tag, ".c3_stall"}, 32'(a_stall), 32'd0);
    chk({tag, ".c3_write"}, 32'(a_write), 32'(exp_w));
    chk({tag, ".c3_fault"}, 32'(a_fault), 32'(exp_f));
    if (exp_w) begin
      chk({tag, ".c3_wdata"}, 32'(a_wdata), 32'(exp_d));
      chk({tag, ".c3_wreg"}, 32'(a_wreg), 32'(dr));
    end
    step(); #1;
    chk({tag, ".c4_write"}, 32'(a_write), 32'd0);
    chk({tag, ".c4_fault"}, 32'(a_fault), 32'd0);
    chk({tag, ".c4_stall"}, 32'(a_stall), 32'd0);
    if (exp_w) chk({tag, ".c4_hold"}, 32'(a_wdata), 32'(exp_d));
  endtask

  initial begin
    reset = 1'b1;
    a_idle(); a_address = '0; a_data = '0; a_dest = '0;
    b_load = 1'b0; b_store = 1'b0; b_address = '0; b_data = '0; b_dest = '0;
    #12;
    chk("rst.stall", 32'(a_stall), 32'd0);
    chk("rst.write", 32'(a_write), 32'd0);
    chk("rst.fault", 32'(a_fault), 32'd0);
    chk("rst.wdata", 32'(a_wdata), 32'd0);
    chk("rst.wreg",  32'(a_wreg),  32'd0);
    reset = 1'b0;
    step();

    // Reset during WAIT of a store must abort it.
    txn1("pre", 1'b0, 1'b1, 16'h0010, 16'h1111, 4'd0, 1'b0, 16'h0, 1'b0);
    a_store = 1'b1; a_address = 16'h0010; a_data = 16'hBEEF;
    step(); a_idle(); #1;
    chk("t1.in_wait", 32'(a_stall), 32'd1);
    reset = 1'b1; #1;
    chk("t1.stall", 32'(a_stall), 32'd0);
    chk("t1.write", 32'(a_write), 32'd0);
    chk("t1.fault", 32'(a_fault), 32'd0);
    reset = 1'b0;
    step();
    chk("t1.no_pulse", 32'(a_write), 32'd0);
    step(); step();
    chk("t1.idle", 32'(a_stall), 32'd0);
    txn1("t1.load", 1'b1, 1'b0, 16'h0010, 16'h0, 4'd1, 1'b1, 16'h1111, 1'b0);

    txn1("t2.store", 1'b0, 1'b1, 16'h0005, 16'h1234, 4'd0, 1'b0, 16'h0, 1'b0);
    txn1("t3.load", 1'b1, 1'b0, 16'h0005, 16'h0, 4'd2, 1'b1, 16'h1234, 1'b0);

    // Out-of-range accesses fault and never touch RAM[0].
    txn1("t5.st0", 1'b0, 1'b1, 16'h0000, 16'h5555, 4'd0, 1'b0, 16'h0, 1'b0);
    txn1("t5.ldoor", 1'b1, 1'b0, 16'h0100, 16'h0, 4'd3, 1'b1, 16'h0000, 1'b1);
    txn1("t5.stoor", 1'b0, 1'b1, 16'h0100, 16'hDEAD, 4'd0, 1'b0, 16'h0, 1'b1);
    txn1("t5.ld0", 1'b1, 1'b0, 16'h0000, 16'h0, 4'd4, 1'b1, 16'h5555, 1'b0);

    txn1("t6.both", 1'b1, 1'b1, 16'h0003, 16'h00FF, 4'd6, 1'b0, 16'h0, 1'b1);
    txn1("t6.ld3", 1'b1, 1'b0, 16'h0003, 16'h0, 4'd5, 1'b1, 16'h00FF, 1'b0);

    txn1("dest_hi", 1'b1, 1'b0, 16'h0005, 16'h0, 4'hA, 1'b1, 16'h1234, 1'b0);

    // Zero-wait port: back-to-back traffic issued in RESP cycles.
    b_store = 1'b1; b_address = 16'h0000; b_data = 16'hAAAA; #1;
    chk("t4.c0_stall", 32'(b_stall), 32'd1);
    step(); b_store = 1'b0; #1;
    chk("t4.c1_stall", 32'(b_stall), 32'd1);
    step();
    b_store = 1'b1; b_address = 16'h0001; b_data = 16'hBBBB; #1;
    chk("t4.c2_stall", 32'(b_stall), 32'd1);
    step(); b_store = 1'b0; #1;
    step();
    b_load = 1'b1; b_address = 16'h0000; b_dest = 4'd6; #1;
    chk("t4.c4_write", 32'(b_write), 32'd0);
    step(); b_load = 1'b0; #1;
    chk("t4.c5_write", 32'(b_write), 32'd0);
    step();
    b_load = 1'b1; b_address = 16'h0001; b_dest = 4'd7; #1;
    chk("t4.p1_write", 32'(b_write), 32'd1);
    chk("t4.p1_wdata", 32'(b_wdata), 32'h0000AAAA);
    chk("t4.p1_wreg",  32'(b_wreg),  32'd6);
    chk("t4.p1_stall", 32'(b_stall), 32'd1);
    step(); b_load = 1'b0; #1;
    chk("t4.gap_write", 32'(b_write), 32'd0);
    chk("t4.gap_hold",  32'(b_wdata), 32'h0000AAAA);
    step(); #1;
    chk("t4.p2_write", 32'(b_write), 32'd1);
    chk("t4.p2_wdata", 32'(b_wdata), 32'h0000BBBB);
    chk("t4.p2_wreg",  32'(b_wreg),  32'd7);
    chk("t4.p2_fault", 32'(b_fault), 32'd0);
    step(); #1;
    chk("t4.end_write", 32'(b_write), 32'd0);
    chk("t4.end_stall", 32'(b_stall), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/data_mem_port.md
Name: data_mem_port

Overview:
- Memory-side end of the register file's memory interface.
- Consumes the address register value, store data from the register file's memory-data output, and the load destination index.
- Performs the access on an internal word-addressed data RAM with a configurable number of wait states, stalling the pipeline while the access is in progress.
- Returns load results as a one-cycle register-file write (data, register index, write strobe).

Parameters:
- ADDR_W, 8, RAM index width; depth is 2**ADDR_W 16-bit words.
- WAIT_CYCLES, 1, wait states inserted before the access; 0..15 legal.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- load  in  1  load request, sampled when the block is accepting.
- store  in  1  store request, sampled when the block is accepting.
- address  in  16  word address, taken from the register file's address output.
- dataToMem  in  16  store data.
- destReg  in  4  load destination register index, 0..7.
- stall  out  1  pipeline hold.
- writeData  out  16  load result to the register file.
- writeReg  out  4  destination index, echoed from the request.
- write  out  1  one-cycle register-file write strobe.
- fault  out  1  one-cycle error pulse.

Behaviour:
- Reset: already decided — one clock; reset is asynchronous and active-high. State goes to IDLE. stall=0, write=0, fault=0, writeData=0, writeReg=0, wait counter=0. RAM contents are not reset.
- Reset mid-operation aborts the request. A pending store is never written. No write pulse is produced.
- States: IDLE, WAIT, ACCESS, RESP.
- Acceptance happens in IDLE or RESP when load|store=1:
  - Latch address, dataToMem, destReg and the operation type.
  - Go to WAIT if WAIT_CYCLES>0, else go to ACCESS.
  - stall=1 combinationally in the accepting cycle.
- WAIT:
  - Counter loads WAIT_CYCLES-1 on entry and decrements each cycle.
  - At 0, go to ACCESS. WAIT lasts exactly WAIT_CYCLES cycles.
  - stall=1.
- ACCESS:
  - stall=1.
  - On the closing edge, a store writes RAM[addr[ADDR_W-1:0]].
  - On the closing edge, a load registers the RAM word into writeData, sets writeReg to the latched destReg, and sets write=1.
  - Next state is RESP.
- RESP:
  - stall=0.
  - write=1 for exactly this cycle for a load; 0 for a store.
  - A new request may be accepted here, same as in IDLE. Otherwise go to IDLE.
- Load latency: the request is accepted in cycle 0 and write is asserted in cycle WAIT_CYCLES+2.
- stall is high for cycles 0..WAIT_CYCLES+1.
- writeData and writeReg hold their last values outside RESP.
- load and store both high: treated as a store. fault pulses in the ACCESS→RESP cycle.
- Out-of-range address (any of address[15:ADDR_W] nonzero):
  - No RAM access.
  - A load returns writeData=0 with write still pulsed.
  - A store is dropped.
  - fault pulses in the RESP cycle.
- destReg>7: passed through unchanged; the register file ignores it.
- Inputs are ignored in WAIT and ACCESS.

Decomposition:
- Shared package cpu_pkg holds:
  - State encoding: IDLE=2'd0, WAIT=2'd1, ACCESS=2'd2, RESP=2'd3.
  - DATA_W=16.
  - REG_IDX_W=4.
- One sub-module, dmem_ram:
  - Single-port synchronous RAM with ports clk, we, addr[ADDR_W], wdata[16], rdata[16].
  - Registered read.
  - No reset.

Test Plan:
1. Reset asserted mid-WAIT of a store to 0x0010 with data 0xBEEF -> outputs 0 immediately, no write pulse. A later load from 0x0010 returns the prior contents, not 0xBEEF.
2. WAIT_CYCLES=1: store 0x1234 to address 0x0005 in cycle 0 -> stall high in cycles 0-2, low in cycle 3, write=0 throughout.
3. WAIT_CYCLES=1: following the store, load 0x0005 with destReg=2 -> in cycle 3 after acceptance, write=1, writeData=0x1234, writeReg=2, for one cycle only.
4. WAIT_CYCLES=0: back-to-back loads from 0x00 and 0x01, the second issued in the RESP cycle of the first -> two write pulses 2 cycles apart with correct data.
5. load from address 0x0100 (ADDR_W=8) -> fault=1 and write=1 with writeData=0 in the RESP cycle. A store to 0x0100 leaves RAM[0x00] unchanged.
6. load=store=1, address 0x0003, data 0x00FF -> RAM[3]=0x00FF, fault pulse, write=0.
